// File: rtl/ik_swift_loader.sv
// ik_swift_loader: Avalon-MM register front end for the ik_swift solver core.
// Holds the solver inputs, sequences a programmable number of solver iterations
// (feeding each result back in as the next input), and reports progress,
// completion and timeout through status registers and a level interrupt.
module ik_swift_loader #(
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned MAX_ITER_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             avs_address,
    input  logic                   avs_chipselect,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic [31:0]            avs_readdata,
    output logic                   irq,
    output logic                   ik_en,
    output logic                   ik_rst,
    output logic [2:0][35:0]       ik_z,
    output logic [5:0]             ik_joint_type,
    output logic [5:0][3:0][35:0]  ik_dh_param_in,
    output logic [5:0][35:0]       ik_target,
    input  logic                   ik_done,
    input  logic [5:0][3:0][35:0]  ik_dh_param_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        CAPTURE
    } state_t;

    state_t                  state;
    logic [5:0][3:0][35:0]   dh_in;
    logic [5:0][35:0]        target;
    logic [2:0][35:0]        z;
    logic [5:0]              joint_type;
    logic [MAX_ITER_W-1:0]   iter_count;
    logic [MAX_ITER_W-1:0]   iter_done;
    logic                    done_flag;
    logic                    timeout_flag;
    logic [CNT_W-1:0]        tcnt;

    logic                    wr;
    logic                    ctrl_wr;
    logic                    start_cmd;
    logic                    abort_cmd;
    logic                    busy;
    logic [1:0]              z_idx;
    logic [4:0]              out_word;
    logic [35:0]             rword;
    logic                    rhit;
    logic [31:0]             rdata;
    logic [MAX_ITER_W:0]     iter_next;
    logic [MAX_ITER_W:0]     iter_goal;
    logic [CNT_W-1:0]        tcnt_next;

    assign ik_dh_param_in = dh_in;
    assign ik_target      = target;
    assign ik_z           = z;
    assign ik_joint_type  = joint_type;
    assign irq            = done_flag | timeout_flag;
    assign busy           = (state != IDLE);

    // Command decode, address-to-index helpers and iteration arithmetic
    always_comb begin
        wr        = avs_chipselect & avs_write;
        ctrl_wr   = wr && (avs_address == 7'h43);
        abort_cmd = ctrl_wr & avs_writedata[1];
        start_cmd = ctrl_wr & avs_writedata[0] & ~avs_writedata[1];
        // z words start at 0x3C, which is not a power-of-two boundary
        case (avs_address[6:1])
            6'h1E:   z_idx = 2'd0;
            6'h1F:   z_idx = 2'd1;
            default: z_idx = 2'd2;
        endcase
        // 0x50..0x7F maps onto the flat 0..23 word index of the result array
        out_word  = avs_address[5:1] - 5'h08;
        iter_next = {1'b0, iter_done} + (MAX_ITER_W+1)'(1);
        iter_goal = (iter_count == '0) ? (MAX_ITER_W+1)'(1) : {1'b0, iter_count};
        tcnt_next = tcnt + CNT_W'(1);
    end

    // Read mux: 36-bit values split into a low word and a sign-extended high nibble
    always_comb begin
        rword = '0;
        rhit  = 1'b0;
        rdata = '0;
        if (avs_address < 7'h30) begin
            rword = dh_in[avs_address[5:3]][avs_address[2:1]];
            rhit  = 1'b1;
        end else if (avs_address < 7'h3C) begin
            rword = target[avs_address[3:1]];
            rhit  = 1'b1;
        end else if (avs_address < 7'h42) begin
            rword = z[z_idx];
            rhit  = 1'b1;
        end else if (avs_address >= 7'h50) begin
            rword = ik_dh_param_out[out_word[4:2]][out_word[1:0]];
            rhit  = 1'b1;
        end
        if (rhit) begin
            rdata = avs_address[0] ? {{28{rword[35]}}, rword[35:32]} : rword[31:0];
        end else begin
            case (avs_address)
                7'h42:   rdata[5:0] = joint_type;
                7'h43:   rdata[2:0] = {timeout_flag, done_flag, busy};
                7'h44:   rdata[MAX_ITER_W-1:0] = iter_count;
                7'h45:   rdata[MAX_ITER_W-1:0] = iter_done;
                default: rdata = '0;
            endcase
        end
    end

    // Registered read data, one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            avs_readdata <= '0;
        end else if (avs_chipselect && avs_read) begin
            avs_readdata <= rdata;
        end
    end

    // Register file and iteration sequencer; host data writes only land while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dh_in        <= '0;
            target       <= '0;
            z            <= '0;
            joint_type   <= '0;
            iter_count   <= '0;
            iter_done    <= '0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            tcnt         <= '0;
            ik_en        <= 1'b0;
            ik_rst       <= 1'b0;
        end else if (abort_cmd) begin
            state        <= IDLE;
            ik_en        <= 1'b0;
            ik_rst       <= 1'b0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr) begin
                        if (avs_address < 7'h30) begin
                            if (avs_address[0])
                                dh_in[avs_address[5:3]][avs_address[2:1]][35:32] <= avs_writedata[3:0];
                            else
                                dh_in[avs_address[5:3]][avs_address[2:1]][31:0] <= avs_writedata;
                        end else if (avs_address < 7'h3C) begin
                            if (avs_address[0])
                                target[avs_address[3:1]][35:32] <= avs_writedata[3:0];
                            else
                                target[avs_address[3:1]][31:0] <= avs_writedata;
                        end else if (avs_address < 7'h42) begin
                            if (avs_address[0])
                                z[z_idx][35:32] <= avs_writedata[3:0];
                            else
                                z[z_idx][31:0] <= avs_writedata;
                        end else if (avs_address == 7'h42) begin
                            joint_type <= avs_writedata[5:0];
                        end else if (avs_address == 7'h44) begin
                            iter_count <= avs_writedata[MAX_ITER_W-1:0];
                        end
                    end
                    if (start_cmd) begin
                        done_flag    <= 1'b0;
                        timeout_flag <= 1'b0;
                        iter_done    <= '0;
                        tcnt         <= '0;
                        ik_rst       <= 1'b1;
                        ik_en        <= 1'b0;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ik_rst <= 1'b0;
                    ik_en  <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    tcnt <= tcnt_next;
                    if (ik_done) begin
                        ik_en <= 1'b0;
                        state <= CAPTURE;
                    end else if (tcnt_next == CNT_W'(TIMEOUT)) begin
                        timeout_flag <= 1'b1;
                        ik_en        <= 1'b0;
                        state        <= IDLE;
                    end
                end
                CAPTURE: begin
                    dh_in     <= ik_dh_param_out;
                    iter_done <= iter_next[MAX_ITER_W-1:0];
                    if (iter_next >= iter_goal) begin
                        done_flag <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt   <= '0;
                        ik_rst <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ik_swift_loader.sv
// Testbench for ik_swift_loader: randomized register traffic and solver runs
// checked against a word-level model of the register map and iteration rules.
module tb_ik_swift_loader;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [6:0]            avs_address = '0;
    logic                  avs_chipselect = 1'b0;
    logic                  avs_read = 1'b0;
    logic                  avs_write = 1'b0;
    logic [31:0]           avs_writedata = '0;
    logic [31:0]           avs_readdata;
    logic                  irq;
    logic                  ik_en;
    logic                  ik_rst;
    logic [2:0][35:0]      ik_z;
    logic [5:0]            ik_joint_type;
    logic [5:0][3:0][35:0] ik_dh_param_in;
    logic [5:0][35:0]      ik_target;
    logic                  ik_done;
    logic [5:0][3:0][35:0] ik_dh_param_out;

    ik_swift_loader #(.TIMEOUT(64), .MAX_ITER_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .irq             (irq),
        .ik_en           (ik_en),
        .ik_rst          (ik_rst),
        .ik_z            (ik_z),
        .ik_joint_type   (ik_joint_type),
        .ik_dh_param_in  (ik_dh_param_in),
        .ik_target       (ik_target),
        .ik_done         (ik_done),
        .ik_dh_param_out (ik_dh_param_out)
    );

    always #5 clk = ~clk;

    // Solver stand-in: done after sol_lat enabled cycles, result = input + 1
    int sol_lat = 10;
    bit sol_on  = 1'b1;
    int sol_cnt = 0;
    always @(posedge clk) sol_cnt <= ik_en ? sol_cnt + 1 : 0;
    assign ik_done = sol_on && ik_en && (sol_cnt >= sol_lat);
    always_comb begin
        for (int j = 0; j < 6; j++)
            for (int p = 0; p < 4; p++)
                ik_dh_param_out[j][p] = ik_dh_param_in[j][p] + 36'd1;
    end

    // Activity monitors
    int rst_pulses = 0;
    int en_cycles  = 0;
    always @(posedge clk) begin
        if (ik_rst) rst_pulses <= rst_pulses + 1;
        if (ik_en)  en_cycles  <= en_cycles + 1;
    end

    // Reference model of the host-visible state
    logic [35:0] m_dh [24];
    logic [35:0] m_tg [6];
    logic [35:0] m_z  [3];
    logic [5:0]  m_jt;
    logic [7:0]  m_ic, m_idone;
    logic        m_done, m_to;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_dh[k]) m_dh[k] = '0;
        foreach (m_tg[k]) m_tg[k] = '0;
        foreach (m_z[k])  m_z[k]  = '0;
        m_jt = '0; m_ic = '0; m_idone = '0; m_done = 1'b0; m_to = 1'b0;
    endtask

    function automatic logic [35:0] merge(input logic [35:0] old, input int a, input logic [31:0] d);
        if (a % 2 == 1) return {d[3:0], old[31:0]};
        return {old[35:32], d};
    endfunction

    task automatic model_write(input int a, input logic [31:0] d);
        if (a < 'h30)       m_dh[a/2] = merge(m_dh[a/2], a, d);
        else if (a < 'h3C)  m_tg[(a-'h30)/2] = merge(m_tg[(a-'h30)/2], a, d);
        else if (a < 'h42)  m_z[(a-'h3C)/2] = merge(m_z[(a-'h3C)/2], a, d);
        else if (a == 'h42) m_jt = d[5:0];
        else if (a == 'h44) m_ic = d[7:0];
    endtask

    function automatic logic [31:0] exp_read(input int a);
        logic [35:0] v;
        if (a < 'h30)       v = m_dh[a/2];
        else if (a < 'h3C)  v = m_tg[(a-'h30)/2];
        else if (a < 'h42)  v = m_z[(a-'h3C)/2];
        else if (a >= 'h50) v = m_dh[(a-'h50)/2] + 36'd1;
        else begin
            case (a)
                'h42:    return {26'd0, m_jt};
                'h43:    return {29'd0, m_to, m_done, 1'b0};
                'h44:    return {24'd0, m_ic};
                'h45:    return {24'd0, m_idone};
                default: return 32'd0;
            endcase
        end
        if (a % 2 == 1) return v[35] ? {28'hFFFFFFF, v[35:32]} : {28'd0, v[35:32]};
        return v[31:0];
    endfunction

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        avs_address = 7'(a); avs_writedata = d; avs_chipselect = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge clk);
        avs_address = 7'(a); avs_chipselect = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_chipselect = 1'b0; avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic check_read(input string tag, input int a);
        logic [31:0] d;
        bus_read(a, d);
        check($sformatf("%s@%0h", tag, a), d, exp_read(a));
    endtask

    task automatic check_ports(input string tag);
        for (int k = 0; k < 24; k++)
            check($sformatf("%s_dh%0d", tag, k), ik_dh_param_in[k/4][k%4], m_dh[k]);
        for (int k = 0; k < 6; k++)
            check($sformatf("%s_tg%0d", tag, k), ik_target[k], m_tg[k]);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_z%0d", tag, k), ik_z[k], m_z[k]);
        check($sformatf("%s_jt", tag), ik_joint_type, m_jt);
    endtask

    task automatic wait_irq(input string tag);
        int i = 0;
        while (!irq && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check(tag, irq, 1);
    endtask

    task automatic run_job(input int ic, input int lat);
        int p0, n;
        sol_on = 1'b1; sol_lat = lat;
        bus_write('h44, ic); model_write('h44, ic);
        p0 = rst_pulses;
        bus_write('h43, 32'h1);
        wait_irq("job_irq");
        n = (ic == 0) ? 1 : ic;
        foreach (m_dh[k]) m_dh[k] = m_dh[k] + 36'(n);
        m_idone = 8'(n); m_done = 1'b1; m_to = 1'b0;
        check("job_rst_pulses", rst_pulses - p0, n);
        check("job_en_low", ik_en, 0);
        check_ports("job");
        check_read("job_status", 'h43);
        check_read("job_iter_done", 'h45);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int p0, e0, i;
        model_reset();

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_en", ik_en, 0);
        check("rst_ikrst", ik_rst, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", avs_readdata, 0);
        check_ports("rst");
        rst = 1'b0;
        check_read("rst_status", 'h43);
        check_read("rst_iter_done", 'h45);

        // Split 36-bit access
        bus_write('h04, 32'h87654321); model_write('h04, 32'h87654321);
        bus_write('h05, 32'h9);        model_write('h05, 32'h9);
        check("split_port", ik_dh_param_in[0][2], 36'h987654321);
        bus_read('h05, d); check("split_hi", d, 32'hFFFFFFF9);
        bus_read('h04, d); check("split_lo", d, 32'h87654321);

        // Random register traffic, then full readback
        for (int n = 0; n < 60; n++) begin
            int a;
            logic [31:0] wd;
            a  = $urandom_range(0, 127);
            wd = $urandom;
            if (a == 'h43) continue;
            bus_write(a, wd);
            model_write(a, wd);
        end
        check_ports("rnd");
        for (int a = 0; a < 128; a++) check_read("rnd_rd", a);

        // Directed three-iteration run, then randomized runs
        run_job(3, 10);
        for (int n = 0; n < 4; n++) run_job($urandom_range(0, 4), $urandom_range(1, 20));

        // Timeout: solver never finishes
        sol_on = 1'b0;
        bus_write('h44, 1); model_write('h44, 1);
        bus_write('h43, 32'h1);
        e0 = en_cycles;
        wait_irq("to_irq");
        m_to = 1'b1; m_done = 1'b0; m_idone = '0;
        check("to_en_cycles", en_cycles - e0, 64);
        check("to_en_low", ik_en, 0);
        check_ports("to");
        check_read("to_status", 'h43);
        check_read("to_iter_done", 'h45);

        // Busy protection and abort
        sol_on = 1'b1; sol_lat = 40;
        bus_write('h44, 2); model_write('h44, 2);
        bus_write('h43, 32'h1);
        m_to = 1'b0; m_idone = '0;
        i = 0;
        while (!ik_en && i < 100) begin @(negedge clk); i++; end
        check("busy_reach_run", ik_en, 1);
        bus_write('h30, 32'hDEADBEEF);
        bus_read('h30, d); check("busy_wr_ignored", d, exp_read('h30));
        check("busy_tg_port", ik_target[0], m_tg[0]);
        bus_write('h43, 32'h1);
        bus_read('h43, d); check("busy_status", d, 32'h1);
        bus_read('h45, d); check("busy_iter_done", d, 32'h0);
        bus_write('h43, 32'h3);
        check("abort_en", ik_en, 0);
        check("abort_ikrst", ik_rst, 0);
        check("abort_irq", irq, 0);
        check_read("abort_status", 'h43);
        check_ports("abort");

        // Reset during the second iteration
        sol_lat = 10;
        bus_write('h44, 3); model_write('h44, 3);
        p0 = rst_pulses;
        bus_write('h43, 32'h1);
        i = 0;
        while (!((rst_pulses - p0) == 2 && ik_en) && i < 500) begin @(negedge clk); i++; end
        check("mid_reach_iter2", ik_en, 1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("mid_en", ik_en, 0);
        check("mid_irq", irq, 0);
        check("mid_rdata", avs_readdata, 0);
        check_ports("mid");
        rst = 1'b0;
        check_read("mid_iter_done", 'h45);
        check_read("mid_status", 'h43);
        check_read("mid_iter_count", 'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ik_swift_loader.md
Name: ik_swift_loader

Overview:
Avalon-MM slave that sits directly upstream of the ik_swift solver core. The HPS writes the solver inputs through it: z axis, joint_type, DH parameters and target. On a start command it sequences the core for a programmable number of iterations. After each iteration it feeds dh_param_out back into dh_param_in. It reports completion, timeout and iteration progress through status registers and a level interrupt.

Parameters:
TIMEOUT, 4096, max cycles ik_en may stay high per iteration before abort
MAX_ITER_W, 8, width of iteration count/progress registers

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
avs_address  in  7  word address
avs_chipselect  in  1  slave select
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
irq  out  1  level interrupt = done_flag | timeout_flag
ik_en  out  1  solver enable, held high until ik_done
ik_rst  out  1  one-cycle solver clear before each iteration
ik_z  out  3x36  packed [2:0][35:0]
ik_joint_type  out  6  joint type vector
ik_dh_param_in  out  6x4x36  packed [5:0][3:0][35:0]
ik_target  out  6x36  packed [5:0][35:0]
ik_done  in  1  solver done
ik_dh_param_out  in  6x4x36  solver result

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- A 36-bit value occupies two words. Even address = bits[31:0]. Odd address = bits[35:32]: write uses writedata[3:0]; read returns bits[35:32] sign-extended to 32 bits. Writing one half leaves the other half unchanged.
- Address map:
  - 0x00-0x2F: dh_param_in[j][p], word = 2*(4j+p)+half
  - 0x30-0x3B: target[i], word = 2i+half
  - 0x3C-0x41: z[i], word = 0x3C+2i+half
  - 0x42: joint_type[5:0]
  - 0x43 CTRL/STATUS. Write: bit0 start, bit1 abort. Read: bit0 busy, bit1 done_flag, bit2 timeout_flag.
  - 0x44: iter_count, RW, MAX_ITER_W bits
  - 0x45: iter_done, RO
  - 0x50-0x7F: live ik_dh_param_out, RO, same packing as 0x00
  - Unmapped reads return 0; unmapped writes are ignored.
- Transactions require chipselect. Read latency is 1 cycle: readdata is valid the cycle after avs_read. No waitrequest.
- All outputs are driven directly from the register file.
- Reset values:
  - All registers 0.
  - ik_en=0, ik_rst=0, irq=0, avs_readdata=0.
  - FSM in IDLE.
- FSM states IDLE, LAUNCH, RUN, CAPTURE:
  - IDLE: a start write clears done_flag, timeout_flag and iter_done, then goes to LAUNCH. Start while busy is ignored.
  - LAUNCH: ik_rst=1 for exactly 1 cycle, ik_en=0, then RUN.
  - RUN: ik_en=1 and the timeout counter increments each cycle.
    - If ik_done=1: go to CAPTURE.
    - Else if the counter reaches TIMEOUT: set timeout_flag, drop ik_en, go to IDLE.
    - ik_done takes priority over timeout in the same cycle.
  - CAPTURE (1 cycle): ik_en=0, dh_param_in <= ik_dh_param_out, iter_done++.
    - If iter_done+1 >= max(iter_count,1): set done_flag, go to IDLE.
    - Else: go to LAUNCH.
- busy = (state != IDLE).
- While busy, host writes to 0x00-0x44 are ignored. Reads are always allowed.
- Abort (CTRL bit1), from any state: next cycle the FSM is IDLE, ik_en=0, and both flags are cleared. Data registers and iter_done are kept. If start and abort are written together, abort wins.
- iter_count=0 behaves as 1.
- The timeout counter clears on entry to LAUNCH.
- rst mid-run: the FSM goes to IDLE and all registers, including dh_param_in, clear on the next edge.
- Flags are sticky until the next start or an abort. irq follows the flags.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0; STATUS reads 0x0; iter_done reads 0.
- Split access: write 0x04=0x87654321, 0x05=0x9 -> ik_dh_param_in[0][2] = 36'h987654321; read 0x05 -> 0xFFFFFFF9; read 0x04 -> 0x87654321 one cycle after avs_read.
- Three iterations:
  - Setup: iter_count=3, start; solver model asserts ik_done 10 cycles after ik_en, with out = in + 1 per element.
  - Expect: exactly 3 ik_rst pulses; final dh_param_in = initial + 3; iter_done=3; STATUS=0x2; irq=1.
- Timeout: TIMEOUT=64, model never asserts done -> ik_en high exactly 64 cycles then low; STATUS=0x4; irq=1; dh_param_in unchanged.
- Busy protection: during RUN, write target[0] low half=0xDEADBEEF -> readback unchanged; a second start has no effect; abort -> next cycle busy=0, ik_en=0, STATUS=0x0.
- Mid-run reset: rst during RUN of iteration 2 -> next cycle ik_en=0, iter_done=0, all inputs 0, irq=0.
